// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - Wishbone-slave PS/2 host-to-device command transmitter
module ps2_host_tx #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        int_o,
    input  logic        kb_clk_i,
    input  logic        kb_dat_i,
    output logic        kb_clk_oe_o,
    output logic        kb_dat_oe_o
);

    localparam int INHIBIT_CYC = CLOCK_FREQ / 1000000 * INHIBIT_US;
    localparam int TIMEOUT_CYC = CLOCK_FREQ / 1000000 * TIMEOUT_US;
    localparam int INH_W       = $clog2(INHIBIT_CYC + 1);
    localparam int TMO_W       = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAITIDLE
    } state_t;

    state_t             state, state_nxt;
    logic [INH_W-1:0]   inh_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [9:0]         tx_sr;
    logic [3:0]         bit_cnt;

    logic               clk_s1, clk_s2, clk_prev;
    logic               dat_s1, dat_s2;
    logic               fe;

    logic               done, nack, tout, ovr, ie;
    logic               busy;

    logic               acc, wr_en;
    logic               tx_wr, st_wr, ctrl_wr;
    logic [31:0]        rdata;

    logic               clk_oe, dat_oe;
    logic               set_done, set_nack, set_tout, shift_en, tmo_load;
    logic               tmo_zero;

    logic               unused_bits;
    assign unused_bits = ^{sel_i, adr_i[31:4], adr_i[1:0], dat_i[31:8]};

    // Lines idle high, so the synchronizers reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= kb_clk_i;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= kb_dat_i;
            dat_s2   <= dat_s1;
        end
    end

    assign fe = clk_prev & ~clk_s2;

    // Bus side: writes commit on the cycle ack_o is high.
    assign acc     = cyc_i & stb_i;
    assign wr_en   = acc & we_i & ack_o;
    assign busy    = (state != S_IDLE);
    assign tx_wr   = wr_en & (adr_i[3:2] == 2'd0) & ~busy;
    assign st_wr   = wr_en & (adr_i[3:2] == 2'd1);
    assign ctrl_wr = wr_en & (adr_i[3:2] == 2'd2);

    always_comb begin
        rdata = 32'h0;
        case (adr_i[3:2])
            2'd1:    rdata = {27'h0, ovr, tout, nack, done, busy};
            2'd2:    rdata = {31'h0, ie};
            default: rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_o <= 1'b0;
            dat_o <= 32'h0;
        end else begin
            ack_o <= acc & ~ack_o;
            dat_o <= (acc & ~we_i & ~ack_o) ? rdata : 32'h0;
        end
    end

    assign tmo_zero = (tmo_cnt == '0);

    always_comb begin
        state_nxt = state;
        clk_oe    = 1'b0;
        dat_oe    = 1'b0;
        set_done  = 1'b0;
        set_nack  = 1'b0;
        set_tout  = 1'b0;
        shift_en  = 1'b0;
        tmo_load  = 1'b0;
        case (state)
            S_IDLE: begin
                if (tx_wr) state_nxt = S_INHIBIT;
            end
            S_INHIBIT: begin
                clk_oe = 1'b1;
                dat_oe = (inh_cnt == '0);
                if (inh_cnt == '0) begin
                    state_nxt = S_REQ;
                    tmo_load  = 1'b1;
                end
            end
            S_REQ: begin
                dat_oe = 1'b1;
                if (tmo_zero) begin
                    set_tout  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (fe) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                dat_oe = ~tx_sr[0];
                if (tmo_zero) begin
                    set_tout  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (fe) begin
                    if (bit_cnt == 4'd9) state_nxt = S_ACK;
                    else                 shift_en  = 1'b1;
                end
            end
            S_ACK: begin
                // Timeout is checked first so it wins over a coincident ack edge.
                if (tmo_zero) begin
                    set_tout  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (fe) begin
                    set_nack  = dat_s2;
                    state_nxt = S_WAITIDLE;
                end
            end
            S_WAITIDLE: begin
                if (clk_s2 & dat_s2) begin
                    set_done  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // OEs are decoded from state so an async reset releases the lines at once.
    assign kb_clk_oe_o = clk_oe;
    assign kb_dat_oe_o = dat_oe;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            inh_cnt <= '0;
            tmo_cnt <= '0;
            tx_sr   <= 10'h0;
            bit_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (tx_wr) begin
                tx_sr   <= {1'b1, ~^dat_i[7:0], dat_i[7:0]};
                bit_cnt <= 4'd0;
                inh_cnt <= INH_W'(INHIBIT_CYC - 1);
            end else begin
                if (state == S_INHIBIT && inh_cnt != '0) inh_cnt <= inh_cnt - 1'b1;
                if (shift_en) begin
                    tx_sr   <= {1'b0, tx_sr[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end
            if (tmo_load)
                tmo_cnt <= TMO_W'(TIMEOUT_CYC - 1);
            else if ((state == S_REQ || state == S_SHIFT || state == S_ACK) && !tmo_zero)
                tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    // A hardware set in the same cycle as a write-1-to-clear keeps the flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            done  <= 1'b0;
            nack  <= 1'b0;
            tout  <= 1'b0;
            ovr   <= 1'b0;
            ie    <= 1'b0;
            int_o <= 1'b0;
        end else begin
            done  <= set_done | (done & ~(st_wr & dat_i[1]));
            nack  <= set_nack | (nack & ~(st_wr & dat_i[2]));
            tout  <= set_tout | (tout & ~(st_wr & dat_i[3]));
            ovr   <= (wr_en & (adr_i[3:2] == 2'd0) & busy) | (ovr & ~(st_wr & dat_i[4]));
            if (ctrl_wr) ie <= dat_i[0];
            int_o <= ie & (done | nack | tout);
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int TMO = 15000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i  = 1'b0;
    logic [3:0]  sel_i = 4'hF;
    logic [31:0] adr_i = 32'h0;
    logic [31:0] dat_i = 32'h0;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        int_o;
    logic        kb_clk_i, kb_dat_i;
    logic        kb_clk_oe_o, kb_dat_oe_o;
    logic        dev_clk_low = 1'b0;
    logic        dev_dat_low = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    assign kb_clk_i = ~(kb_clk_oe_o | dev_clk_low);
    assign kb_dat_i = ~(kb_dat_oe_o | dev_dat_low);

    ps2_host_tx #(
        .CLOCK_FREQ(1000000),
        .INHIBIT_US(100),
        .TIMEOUT_US(15000)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .sel_i(sel_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
        .int_o(int_o), .kb_clk_i(kb_clk_i), .kb_dat_i(kb_dat_i),
        .kb_clk_oe_o(kb_clk_oe_o), .kb_dat_oe_o(kb_dat_oe_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] d,
                           output logic [31:0] r);
        int lat;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we;
        adr_i = {28'h0, a, 2'b00}; dat_i = d;
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (!ack_o && lat < 8);
        check("ack_lat", lat, 1);
        r = dat_o;
        tick(1);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        wb_xfer(1'b1, a, d, r);
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] r);
        wb_xfer(1'b0, a, 32'h0, r);
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back({21'h0, 1'b1, ~^b, b, 1'b0});
        wb_write(2'd0, {24'h0, b});
    endtask

    task automatic wait_idle();
        logic [31:0] r;
        int n;
        n = 0;
        do begin
            wb_read(2'd1, r);
            n++;
        end while (r[0] && n < 500);
        check("idle_wait", r[0], 0);
    endtask

    // Device: clocks at 100 clk_i per period, samples data on rising edges.
    task automatic dev_rx(input bit do_ack);
        logic [10:0] fr;
        logic        d_first, d_last;
        int          n, inh;
        n = 0;
        while (!kb_clk_oe_o && n < 1000) begin tick(1); n++; end
        inh = 0; d_first = kb_dat_oe_o; d_last = 1'b0;
        while (kb_clk_oe_o && inh < 1000) begin d_last = kb_dat_oe_o; inh++; tick(1); end
        check("inhibit_len", inh, INH);
        check("start_first", d_first, 0);
        check("start_last", d_last, 1);
        tick(50);
        fr[0] = kb_dat_i;
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1; tick(50);
            dev_clk_low = 1'b0; fr[i] = kb_dat_i; tick(50);
        end
        dev_clk_low = 1'b1; tick(50);
        dev_clk_low = 1'b0; tick(25);
        if (do_ack) dev_dat_low = 1'b1;
        tick(25);
        dev_clk_low = 1'b1; tick(50);
        dev_clk_low = 1'b0; tick(10);
        dev_dat_low = 1'b0;
        if (exp_q.size() == 0) check("sb_empty", 1, 0);
        else                   check("frame", {21'h0, fr}, exp_q.pop_front());
    endtask

    initial begin
        logic [31:0] r;
        int n;

        tick(3);
        check("rst_ack", ack_o, 0);
        check("rst_int", int_o, 0);
        check("rst_oe", {kb_clk_oe_o, kb_dat_oe_o}, 0);
        check("rst_dat", dat_o, 0);
        rst_i = 1'b1;
        tick(2);

        wb_read(2'd2, r);
        check("ctrl_rst", r, 0);
        check("ack_gap", ack_o, 0);
        wb_read(2'd1, r);
        check("status_rst", r, 0);
        wb_write(2'd3, 32'hFFFF_FFFF);
        wb_read(2'd3, r);
        check("adr3", r, 0);
        wb_write(2'd2, 32'h1);
        wb_read(2'd2, r);
        check("ctrl_ie", r, 1);

        fork
            send_byte(8'hED);
            dev_rx(1'b1);
        join
        wait_idle();
        wb_read(2'd1, r);
        check("status_done", r, 32'h02);
        check("int_done", int_o, 1);
        wb_write(2'd1, 32'h1E);
        tick(1);
        check("int_clear", int_o, 0);
        wb_read(2'd1, r);
        check("status_clr", r, 0);

        fork
            send_byte(8'hED);
            dev_rx(1'b0);
        join
        wait_idle();
        wb_read(2'd1, r);
        check("status_nack", r, 32'h06);
        wb_write(2'd1, 32'h1E);

        fork
            begin
                send_byte(8'hED);
                wb_write(2'd0, 32'h55);
                wb_write(2'd0, 32'h12);
            end
            dev_rx(1'b1);
        join
        wait_idle();
        wb_read(2'd1, r);
        check("status_ovr", r, 32'h12);
        check("int_ovr", int_o, 1);
        wb_write(2'd1, 32'h1E);

        wb_write(2'd2, 32'h0);
        wb_write(2'd0, 32'hFF);
        tick(INH + TMO - 5);
        check("tout_early", kb_dat_oe_o, 1);
        tick(10);
        check("tout_oe", {kb_clk_oe_o, kb_dat_oe_o}, 0);
        wb_read(2'd1, r);
        check("status_tout", r, 32'h08);
        check("int_tout_ie0", int_o, 0);
        wb_write(2'd2, 32'h1);
        tick(1);
        check("int_tout_ie1", int_o, 1);
        wb_write(2'd1, 32'h1E);

        wb_write(2'd0, 32'hF4);
        n = 0;
        while (!kb_clk_oe_o && n < 100) begin tick(1); n++; end
        while (kb_clk_oe_o && n < 500) begin tick(1); n++; end
        check("req_reached", kb_clk_oe_o, 0);
        for (int i = 0; i < 2; i++) begin
            dev_clk_low = 1'b1; tick(20);
            dev_clk_low = 1'b0; tick(20);
        end
        check("shift_dat_oe", kb_dat_oe_o, 1);
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        #1 check("rst_async_oe", {kb_clk_oe_o, kb_dat_oe_o}, 0);
        tick(3);
        rst_i = 1'b1;
        tick(2);
        wb_read(2'd1, r);
        check("status_after_rst", r, 0);
        fork
            send_byte(8'hF4);
            dev_rx(1'b1);
        join
        wait_idle();
        wb_read(2'd1, r);
        check("status_f4", r, 32'h02);
        check("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
